// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with wrap or saturate
// boundary mode, synchronous Gray load and sticky overflow.
module gray_counter_n #(
   parameter int WIDTH    = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] Load_gray,
   input  logic             Clr_ovf,
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] Count_bin,
   output logic             Overflow,
   output logic             Wrap
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONES = '1;

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gry_q, gry_d;
   logic             ovf_q, ovf_d;
   logic             wrap_q, wrap_d;
   logic             at_top, at_bot, bnd;

   function automatic logic [WIDTH-1:0] g2b(
      input logic [WIDTH-1:0] g
   );
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH-2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] b2g(
      input logic [WIDTH-1:0] b
   );
      return b ^ (b >> 1);
   endfunction

   assign at_top = (bin_q == ONES);
   assign at_bot = (bin_q == ZERO);
   assign bnd    = Up ? at_top : at_bot;

   always_comb begin
      bin_d  = bin_q;
      gry_d  = gry_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q & ~Clr_ovf;
      if (Load) begin
         bin_d = g2b(Load_gray);
         gry_d = Load_gray;
      end else if (En) begin
         if (bnd) begin
            // set beats a same-edge clear
            ovf_d = 1'b1;
            if (!SATURATE) begin
               bin_d  = Up ? ZERO : ONES;
               wrap_d = 1'b1;
            end
         end else begin
            bin_d = Up ? bin_q + ONE
                       : bin_q - ONE;
         end
         gry_d = b2g(bin_d);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         bin_q  <= '0;
         gry_q  <= '0;
         ovf_q  <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gry_q  <= gry_d;
         ovf_q  <= ovf_d;
         wrap_q <= wrap_d;
      end
   end

   assign Output    = gry_q;
   assign Count_bin = bin_q;
   assign Overflow  = ovf_q;
   assign Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: three instances
// (W3 wrap, W4 wrap, W3 saturate) on shared stimulus.
module tb_gray_counter_n;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       En = 1'b0;
   logic       Up = 1'b0;
   logic       Load = 1'b0;
   logic [3:0] Lg = 4'd0;
   logic       Clr = 1'b0;

   logic [2:0] gA, bA, gC, bC;
   logic [3:0] gB, bB;
   logic       oA, wA, oB, wB, oC, wC;

   gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) uA (
      .Clk(Clk), .Reset(Reset), .En(En), .Up(Up),
      .Load(Load), .Load_gray(Lg[2:0]), .Clr_ovf(Clr),
      .Output(gA), .Count_bin(bA),
      .Overflow(oA), .Wrap(wA));

   gray_counter_n #(.WIDTH(4), .SATURATE(1'b0)) uB (
      .Clk(Clk), .Reset(Reset), .En(En), .Up(Up),
      .Load(Load), .Load_gray(Lg), .Clr_ovf(Clr),
      .Output(gB), .Count_bin(bB),
      .Overflow(oB), .Wrap(wB));

   gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) uC (
      .Clk(Clk), .Reset(Reset), .En(En), .Up(Up),
      .Load(Load), .Load_gray(Lg[2:0]), .Clr_ovf(Clr),
      .Output(gC), .Count_bin(bC),
      .Overflow(oC), .Wrap(wC));

   always #5 Clk = ~Clk;

   typedef struct {
      int         id;
      logic [3:0] g;
      logic [3:0] b;
      logic       o;
      logic       w;
      bit         one;
      string      nm;
   } exp_t;

   exp_t q[$];
   event chk_ev;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [3:0] g3 [8] = '{4'd0, 4'd1, 4'd3, 4'd2,
                          4'd6, 4'd7, 4'd5, 4'd4};
   logic [3:0] g4 [16] = '{4'd0, 4'd1, 4'd3, 4'd2,
                           4'd6, 4'd7, 4'd5, 4'd4,
                           4'd12, 4'd13, 4'd15, 4'd14,
                           4'd10, 4'd11, 4'd9, 4'd8};

   task automatic exp_push(input int id,
                           input logic [3:0] g,
                           input logic [3:0] b,
                           input logic o, input logic w,
                           input bit one, input string nm);
      exp_t e;
      e.id = id; e.g = g; e.b = b;
      e.o = o; e.w = w; e.one = one; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic tick(input logic en, input logic up,
                       input logic ld,
                       input logic [3:0] g,
                       input logic clr);
      @(negedge Clk);
      En = en; Up = up; Load = ld; Lg = g; Clr = clr;
      @(posedge Clk);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      En = 0; Up = 0; Load = 0; Lg = 0; Clr = 0;
      Reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++)
         exp_push(i, 4'd0, 4'd0, 0, 0, 0, "reset");
      ->chk_ev;
      #1 Reset = 1'b1;
   endtask

   // monitor: drains the scoreboard on each sample point
   initial begin : monitor
      exp_t       e;
      logic [3:0] ag, ab;
      logic       ao, aw;
      logic [3:0] prev [3];
      for (int i = 0; i < 3; i++) prev[i] = 4'd0;
      forever begin
         @(negedge Clk or chk_ev);
         while (q.size() > 0) begin
            e = q.pop_front();
            case (e.id)
               0: begin
                  ag = {1'b0, gA}; ab = {1'b0, bA};
                  ao = oA; aw = wA;
               end
               1: begin
                  ag = gB; ab = bB; ao = oB; aw = wB;
               end
               default: begin
                  ag = {1'b0, gC}; ab = {1'b0, bC};
                  ao = oC; aw = wC;
               end
            endcase
            n_tests++;
            if (ag !== e.g || ab !== e.b ||
                ao !== e.o || aw !== e.w) begin
               n_fail++;
               $display("FAIL %s dut%0d: got g=%b b=%0d ovf=%b wrap=%b, want g=%b b=%0d ovf=%b wrap=%b",
                        e.nm, e.id, ag, ab, ao, aw,
                        e.g, e.b, e.o, e.w);
            end
            if (e.one) begin
               n_tests++;
               if ($countones(prev[e.id] ^ ag) != 1) begin
                  n_fail++;
                  $display("FAIL %s_1bit dut%0d: got %b -> %b, want one bit change",
                           e.nm, e.id, prev[e.id], ag);
               end
            end
            prev[e.id] = ag;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin : stim
      int b;
      int n;
      do_reset();

      // W3 wrap: up-count through wrap
      for (int k = 1; k <= 9; k++) begin
         tick(1, 1, 0, 4'd0, 0);
         b = k % 8;
         exp_push(0, g3[b], 4'(b), k >= 8, k == 8, 0, "up3");
      end

      // W4 wrap: down wrap from 0, then clear
      do_reset();
      tick(1, 0, 0, 4'd0, 0);
      exp_push(1, 4'b1000, 4'd15, 1, 1, 0, "dnwrap4");
      tick(0, 0, 0, 4'd0, 1);
      exp_push(1, 4'b1000, 4'd15, 0, 0, 0, "clrovf4");

      // W3 saturate
      do_reset();
      tick(0, 0, 1, 4'b0100, 0);
      exp_push(2, 4'b0100, 4'd7, 0, 0, 0, "satload");
      for (int k = 0; k < 3; k++) begin
         tick(1, 1, 0, 4'd0, 0);
         exp_push(2, 4'b0100, 4'd7, 1, 0, 0, "sathold");
      end
      tick(1, 0, 0, 4'd0, 0);
      exp_push(2, 4'b0101, 4'd6, 1, 0, 0, "satdn");

      // W4 load priority over En
      do_reset();
      tick(1, 1, 1, 4'b1101, 0);
      exp_push(1, 4'b1101, 4'd9, 0, 0, 0, "loadpri");
      tick(1, 1, 0, 4'd0, 0);
      exp_push(1, 4'b1111, 4'd10, 0, 0, 0, "postload");

      // W3 same-edge set and clear
      do_reset();
      tick(0, 0, 1, 4'b0100, 0);
      exp_push(0, 4'b0100, 4'd7, 0, 0, 0, "ld7");
      tick(1, 1, 0, 4'd0, 0);
      exp_push(0, 4'd0, 4'd0, 1, 1, 0, "wrapset");
      tick(0, 0, 1, 4'b0100, 0);
      exp_push(0, 4'b0100, 4'd7, 1, 0, 0, "ld7ovf");
      tick(1, 1, 0, 4'd0, 1);
      exp_push(0, 4'd0, 4'd0, 1, 1, 0, "setwins");
      tick(0, 0, 0, 4'd0, 0);
      exp_push(0, 4'd0, 4'd0, 1, 0, 0, "idlehold");
      tick(0, 0, 0, 4'd0, 1);
      exp_push(0, 4'd0, 4'd0, 0, 0, 0, "clr3");

      // W4 async reset mid-count
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         tick(1, 1, 0, 4'd0, 0);
         exp_push(1, g4[k], 4'(k), 0, 0, 0, "cnt5");
      end
      @(negedge Clk);
      #1 Reset = 1'b0;
      #1 exp_push(1, 4'd0, 4'd0, 0, 0, 0, "async");
      ->chk_ev;
      #1 Reset = 1'b1;
      @(posedge Clk);
      exp_push(1, 4'd1, 4'd1, 0, 0, 0, "postrel");

      // W4 full sweeps, one-bit change each step
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         tick(1, 1, 0, 4'd0, 0);
         b = k % 16;
         exp_push(1, g4[b], 4'(b), k == 16, k == 16, 1, "up4");
      end
      for (int k = 1; k <= 16; k++) begin
         tick(1, 0, 0, 4'd0, 0);
         b = (16 - k) % 16;
         exp_push(1, g4[b], 4'(b), 1, k == 1, 1, "dn4");
      end

      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(negedge Clk);
         n++;
      end
      #1;
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised Gray-code counter with selectable wrap or saturate mode. Generalises the 3-bit up-only Gray counter with sticky overflow.
- Adds the following:
  - WIDTH parameter.
  - Up/down direction.
  - Synchronous load of a Gray-coded value.
  - Overflow flag that sets only on a real boundary event, with software clear.
  - Single-cycle wrap pulse.
- Used as a pointer/sequence source (e.g. FIFO pointers, encoder positions) where adjacent codes must differ by one bit.

Parameters:
- WIDTH, 4, counter and code width in bits; legal range 2..16.
- SATURATE, 0, boundary mode: 0 = wrap modulo 2^WIDTH; 1 = hold at the boundary.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset; 0 resets all state immediately, release is synchronous to Clk.
- En  input  1  count enable; one step per cycle while high.
- Up  input  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
- Load  input  1  synchronous load strobe.
- Load_gray  input  WIDTH  Gray-coded value loaded when Load=1.
- Clr_ovf  input  1  synchronous clear of Overflow.
- Output  output  WIDTH  current value in Gray code, driven directly from a flop.
- Count_bin  output  WIDTH  current value in binary, driven from a flop.
- Overflow  output  1  sticky boundary-crossing flag.
- Wrap  output  1  one-cycle pulse on a wrap event (SATURATE=0 only).

Behaviour:
- State:
  - Binary register bin[WIDTH-1:0].
  - Gray register gry[WIDTH-1:0], with the invariant gry == bin ^ (bin>>1) at every edge.
  - Overflow flop and Wrap flop.
- Reset (Reset=0, asynchronous):
  - bin=0, gry=0, Output=0, Count_bin=0, Overflow=0, Wrap=0.
  - The reset effect is visible without a clock edge.
- Priority per rising edge, highest first: Load, then En.
  - Load=1:
    - bin <= gray-to-binary(Load_gray), where b[MSB]=g[MSB] and b[i]=b[i+1]^g[i].
    - gry <= Load_gray.
    - Wrap <= 0. Overflow is unchanged, apart from Clr_ovf.
    - En is ignored in the same cycle.
  - Load=0, En=1, Up=1, bin != all-ones: bin <= bin+1.
  - Load=0, En=1, Up=0, bin != 0: bin <= bin-1.
  - Load=0, En=1, boundary case (Up=1 with bin=all-ones, or Up=0 with bin=0):
    - SATURATE=0: bin wraps (all-ones->0 or 0->all-ones), Wrap <= 1, Overflow <= 1.
    - SATURATE=1: bin holds, Wrap <= 0, Overflow <= 1.
  - Load=0, En=0: all state holds, Wrap <= 0.
- Wrap:
  - High for exactly the cycle after a wrap edge.
  - Consecutive wrap events (e.g. WIDTH=2, alternating direction at the boundaries) give back-to-back pulses.
- Overflow:
  - Sticky once set.
  - Clr_ovf=1 clears it on the next edge.
  - If a set event and Clr_ovf occur on the same edge, the set wins (Overflow=1).
  - Overflow is never set by merely sitting at the boundary with En=0.
- Latency:
  - Output and Count_bin reflect a step or load one edge after the inputs are sampled.
  - There is no further pipeline.
- Gray property:
  - For every count step, including wrap, Output changes in exactly one bit.
  - A load may change any number of bits.
- All arithmetic is unsigned, modulo 2^WIDTH. There are no X or undefined states.
- Asynchronous reset during a count or load discards that operation. The first post-release edge behaves as from state 0.

Test Plan:
- Reset then up-count: WIDTH=3, SATURATE=0, Reset pulse low, En=1, Up=1 for 9 cycles.
  - Output follows 000,001,011,010,110,111,101,100,000,001.
  - Wrap=1 only in the cycle after 100->000.
  - Overflow=1 from that cycle on.
- Down wrap and Clr_ovf: WIDTH=4, SATURATE=0, from reset with En=1, Up=0 for 1 cycle.
  - Count_bin=15, Output=1000, Wrap=1, Overflow=1.
  - Then Clr_ovf=1 with En=0: Overflow=0.
- Saturate mode: WIDTH=3, SATURATE=1, Load_gray=100 (bin 7), then En=1, Up=1 for 3 cycles.
  - Count_bin stays 7, Output stays 100, Overflow=1, Wrap never 1.
  - Then Up=0, 1 cycle: Count_bin=6, Output=101.
- Load priority and decode: WIDTH=4, Load=1, Load_gray=1101, En=1, Up=1 on the same edge.
  - Count_bin=9, Output=1101, no increment.
  - Next cycle with En=1: Count_bin=10, Output=1111.
- Same-edge set and clear: WIDTH=3, bin=7, Overflow=1, then En=1, Up=1, Clr_ovf=1 on one edge.
  - Overflow stays 1, Count_bin=0, Wrap=1.
- Async reset mid-count: WIDTH=4, counting with bin=5, drive Reset low between edges.
  - Output=0, Count_bin=0, Overflow=0, Wrap=0 immediately.
  - After release with En=1: Count_bin=1 after the first edge.
  - Also check Output single-bit-change over a full 2^WIDTH cycle sweep in both directions.
